storage_write_arbiter: RTL and testbench
========================================

// Module: storage_write_arbiter
// PURPOSE
// Shares the single storage-manager write port between NUM_REQ independent writers
// (matrix input, random gen, compute-result writeback, ...). Round-robin grant, held
// for a whole matrix transfer (write_request .. write_done), with an inactivity timeout.
// Sits between the handler muxes and the storage manager; replaces mode-based muxing.
// PARAMETERS
// NUM_REQ      3       number of requesters (2..8)
// DATA_WIDTH   32      matrix element width
// TIMEOUT_CYC  65535   idle cycles in ACTIVE before forced release (0 = disabled)
// PORTS
// clk              in   1                 clock
// rst_n            in   1                 async active-low reset
// req_write_request in  NUM_REQ           per-requester write_request (level)
// req_matrix_id    in   NUM_REQ*3         packed, requester i at [3i+:3]
// req_actual_rows  in   NUM_REQ*8         packed
// req_actual_cols  in   NUM_REQ*8         packed
// req_matrix_name  in   NUM_REQ*64        packed, char k of req i at [64i+8k+:8]
// req_data_in      in   NUM_REQ*DATA_WIDTH packed
// req_data_valid   in   NUM_REQ           per-requester data strobe
// req_write_ready  out  NUM_REQ           storage write_ready, routed to granted req only
// req_writer_ready out  NUM_REQ           storage writer_ready, routed to granted req only
// req_write_done   out  NUM_REQ           storage write_done, routed to granted req only
// write_request    out  1                 to storage manager
// matrix_id        out  3 / actual_rows out 8 / actual_cols out 8 / matrix_name out 64
// data_in          out  DATA_WIDTH        to storage manager
// data_valid       out  1                 to storage manager
// write_ready      in 1 / writer_ready in 1 / write_done in 1   from storage manager
// grant            out  NUM_REQ           one-hot current owner, 0 when idle
// busy             out  1                 state != IDLE
// timeout_err      out  1                 1-cycle pulse on forced release
// BEHAVIOUR
// - Reset: state IDLE, grant 0, rr_ptr 0, timeout counter 0; all outputs 0.
// - FSM IDLE -> ACTIVE -> RELEASE -> IDLE.
// - IDLE: if any req_write_request, pick first asserted index scanning rr_ptr, rr_ptr+1,
//   ... mod NUM_REQ; register grant; -> ACTIVE next edge (request-to-grant latency 1).
// - ACTIVE: all storage outputs = granted requester's fields (combinational mux on grant);
//   storage ready/done inputs forwarded only to granted bit, others see 0. Non-granted
//   data_valid is ignored (never reaches storage).
// - ACTIVE exit: write_done=1 -> RELEASE. Granted req drops write_request before any
//   write_ready seen -> RELEASE (abort, no done). Timeout counter reset on any of
//   data_valid/write_ready/write_done; reaching TIMEOUT_CYC -> timeout_err pulse, RELEASE.
// - write_done and timeout in same cycle: done wins, no timeout_err.
// - RELEASE (1 cycle): grant 0, write_request out 0, rr_ptr <= winner+1 mod NUM_REQ;
//   requests ignored this cycle -> IDLE. Min gap between owners: 2 cycles.
// - Outside ACTIVE every storage-side output is 0 (name all zero bytes).
// - Async reset mid-transfer: grant dropped immediately, outputs 0, rr_ptr back to 0.
// - Fairness: a continuously requesting index is granted within NUM_REQ transfers.
// TESTING
// - Req0 alone, rows=2 cols=2, 4 data_valid, write_done -> grant=001 1 cycle after req,
//   4 data beats on data_in, req_write_done[0]=1, grant=000 after RELEASE.
// - Req0,1,2 asserted together from reset, each holds until done -> grants 0,1,2 in order;
//   then req2 and req0 again -> order 0 then 2 (rr_ptr=0 after req2 wins... verify wrap).
// - Req1 granted, req2 pulses data_valid meanwhile -> data_valid out tracks req1 only,
//   req_write_ready[2]=0 throughout.
// - TIMEOUT_CYC=16, granted req stalls after write_ready -> timeout_err pulse at idle
//   cycle 16, grant released, next requester granted 2 cycles later.
// - write_done coincident with timeout expiry -> req_write_done pulse, timeout_err=0.
// - rst_n low mid-stream (after 3 beats) -> grant=0, write_request=0 same cycle; after
//   release of reset req2 request -> granted first from rr_ptr=0 scan only if req0,1 idle.

Source files
------------

// File: rtl/storage_write_arbiter_if.sv
// Bundle between the writer handlers, the write arbiter and the storage
// manager write port. The arbiter takes the slave view.
interface storage_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_write_request;
    logic [NUM_REQ*3-1:0]          req_matrix_id;
    logic [NUM_REQ*8-1:0]          req_actual_rows;
    logic [NUM_REQ*8-1:0]          req_actual_cols;
    logic [NUM_REQ*64-1:0]         req_matrix_name;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in;
    logic [NUM_REQ-1:0]            req_data_valid;
    logic [NUM_REQ-1:0]            req_write_ready;
    logic [NUM_REQ-1:0]            req_writer_ready;
    logic [NUM_REQ-1:0]            req_write_done;

    logic                          write_request;
    logic [2:0]                    matrix_id;
    logic [7:0]                    actual_rows;
    logic [7:0]                    actual_cols;
    logic [63:0]                   matrix_name;
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          data_valid;
    logic                          write_ready;
    logic                          writer_ready;
    logic                          write_done;

    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          timeout_err;

    modport slave (
        input  req_write_request, req_matrix_id, req_actual_rows,
        input  req_actual_cols, req_matrix_name, req_data_in,
        input  req_data_valid,
        output req_write_ready, req_writer_ready, req_write_done,
        output write_request, matrix_id, actual_rows, actual_cols,
        output matrix_name, data_in, data_valid,
        input  write_ready, writer_ready, write_done,
        output grant, busy, timeout_err
    );

    modport master (
        output req_write_request, req_matrix_id, req_actual_rows,
        output req_actual_cols, req_matrix_name, req_data_in,
        output req_data_valid,
        input  req_write_ready, req_writer_ready, req_write_done,
        input  write_request, matrix_id, actual_rows, actual_cols,
        input  matrix_name, data_in, data_valid,
        output write_ready, writer_ready, write_done,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/storage_write_arbiter.sv
// Round-robin owner of the storage-manager write port. A grant is held
// for a whole matrix transfer and is dropped on done, abort or stall.
module storage_write_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    storage_write_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST =
        (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RELEASE
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      rr_ptr;
    logic [CW-1:0]      idle_cnt;
    logic               seen_ready;
    logic               timeout_q;

    logic [IW-1:0]      pick_idx;
    logic               pick_vld;
    logic               own_req;
    logic               own_valid;

    // Round-robin scan starting at rr_ptr, first asserted request wins
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld &&
                bus.req_write_request[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign own_req   = |(grant_q & bus.req_write_request);
    assign own_valid = |(grant_q & bus.req_data_valid);

    // Ownership FSM: grant, round-robin pointer and inactivity watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_q    <= '0;
            owner      <= '0;
            rr_ptr     <= '0;
            idle_cnt   <= '0;
            seen_ready <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    idle_cnt   <= '0;
                    seen_ready <= 1'b0;
                    if (pick_vld) begin
                        state   <= ACTIVE;
                        owner   <= pick_idx;
                        grant_q <= ONE << pick_idx;
                    end
                end
                ACTIVE: begin
                    if (bus.write_ready) begin
                        seen_ready <= 1'b1;
                    end
                    if (bus.write_done) begin
                        state   <= RELEASE;
                        grant_q <= '0;
                    end else if (!own_req && !seen_ready &&
                                 !bus.write_ready) begin
                        state   <= RELEASE;
                        grant_q <= '0;
                    end else if (own_valid || bus.write_ready) begin
                        idle_cnt <= '0;
                    end else if (TIMEOUT_CYC != 0) begin
                        if (idle_cnt == TO_LAST) begin
                            state     <= RELEASE;
                            grant_q   <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    state  <= IDLE;
                    rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IW'(1);
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Storage-side mux; grant is zero outside ACTIVE so all outputs idle at 0
    always_comb begin
        bus.write_request = 1'b0;
        bus.matrix_id     = '0;
        bus.actual_rows   = '0;
        bus.actual_cols   = '0;
        bus.matrix_name   = '0;
        bus.data_in       = '0;
        bus.data_valid    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                bus.write_request = bus.req_write_request[i];
                bus.matrix_id     = bus.req_matrix_id[3*i +: 3];
                bus.actual_rows   = bus.req_actual_rows[8*i +: 8];
                bus.actual_cols   = bus.req_actual_cols[8*i +: 8];
                bus.matrix_name   = bus.req_matrix_name[64*i +: 64];
                bus.data_in       = bus.req_data_in[DATA_WIDTH*i +: DATA_WIDTH];
                bus.data_valid    = bus.req_data_valid[i];
            end
        end
    end

    assign bus.req_write_ready  = grant_q & {NUM_REQ{bus.write_ready}};
    assign bus.req_writer_ready = grant_q & {NUM_REQ{bus.writer_ready}};
    assign bus.req_write_done   = grant_q & {NUM_REQ{bus.write_done}};
    assign bus.grant            = grant_q;
    assign bus.busy             = (state != IDLE);
    assign bus.timeout_err      = timeout_q;

endmodule

// File: tb/tb_storage_write_arbiter.sv
// Directed bench for the storage write arbiter: round-robin transfer
// table followed by timeout, abort and reset sequences.
module tb_storage_write_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    storage_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

    storage_write_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_grant;
        logic [31:0]   beat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [NR-1:0] oh);
        int r = 0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    function automatic logic [63:0] name_of(input int i);
        return 64'h4D41_5452_4958_3000 | 64'(i);
    endfunction

    // One complete transfer: grant, foreign strobes, 4 beats, done, release
    task automatic xfer(input logic [NR-1:0] mask, input logic [NR-1:0] exp,
                        input logic [31:0] beat);
        int o;
        o = oh2idx(exp);
        bus.req_write_request = mask;
        tick;
        chk("grant", 64'(bus.grant), 64'(exp));
        chk("busy_act", 64'(bus.busy), 64'd1);
        chk("wr_req_out", 64'(bus.write_request), 64'd1);
        chk("matrix_id", 64'(bus.matrix_id), 64'(o + 1));
        chk("rows", 64'(bus.actual_rows), 64'd2);
        chk("name", bus.matrix_name, name_of(o));
        bus.req_data_valid = ~exp;
        #1;
        chk("foreign_valid", 64'(bus.data_valid), 64'd0);
        bus.write_ready = 1'b1;
        bus.writer_ready = 1'b1;
        #1;
        chk("rd_route", 64'(bus.req_write_ready), 64'(exp));
        chk("wrr_route", 64'(bus.req_writer_ready), 64'(exp));
        tick;
        bus.write_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.req_data_in[o*DW +: DW] = beat + 32'(j);
            bus.req_data_valid = '1;
            #1;
            chk("beat_valid", 64'(bus.data_valid), 64'd1);
            chk("beat_data", 64'(bus.data_in), 64'(beat + 32'(j)));
            tick;
        end
        bus.req_data_valid = '0;
        bus.write_done = 1'b1;
        #1;
        chk("done_route", 64'(bus.req_write_done), 64'(exp));
        tick;
        bus.write_done = 1'b0;
        bus.writer_ready = 1'b0;
        chk("rel_grant", 64'(bus.grant), 64'd0);
        chk("rel_wr_req", 64'(bus.write_request), 64'd0);
        chk("rel_busy", 64'(bus.busy), 64'd1);
        bus.req_write_request[o] = 1'b0;
        tick;
        chk("idle_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{req: 3'b111, exp_grant: 3'b001, beat: 32'h1000};
        vecs[1] = '{req: 3'b110, exp_grant: 3'b010, beat: 32'h2000};
        vecs[2] = '{req: 3'b100, exp_grant: 3'b100, beat: 32'h3000};
        vecs[3] = '{req: 3'b101, exp_grant: 3'b001, beat: 32'h4000};
        vecs[4] = '{req: 3'b100, exp_grant: 3'b100, beat: 32'h5000};
        vecs[5] = '{req: 3'b110, exp_grant: 3'b010, beat: 32'h6000};
        vecs[6] = '{req: 3'b011, exp_grant: 3'b001, beat: 32'h7000};
        vecs[7] = '{req: 3'b001, exp_grant: 3'b001, beat: 32'h8000};

        bus.req_write_request = '0;
        bus.req_data_valid = '0;
        bus.write_ready = 1'b0;
        bus.writer_ready = 1'b0;
        bus.write_done = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.req_matrix_id[3*i +: 3] = 3'(i + 1);
            bus.req_actual_rows[8*i +: 8] = 8'd2;
            bus.req_actual_cols[8*i +: 8] = 8'd2;
            bus.req_matrix_name[64*i +: 64] = name_of(i);
            bus.req_data_in[DW*i +: DW] = 32'hDEAD_0000 + 32'(i);
        end

        tick;
        tick;
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_wr_req", 64'(bus.write_request), 64'd0);
        chk("rst_name", bus.matrix_name, 64'd0);
        chk("rst_tmo", 64'(bus.timeout_err), 64'd0);
        rst_n = 1'b1;
        tick;

        for (int v = 0; v < 8; v++) begin
            xfer(vecs[v].req, vecs[v].exp_grant, vecs[v].beat);
        end

        // stall after write_ready: forced release, then req2 two cycles on
        bus.req_write_request = 3'b110;
        tick;
        chk("to_grant", 64'(bus.grant), 64'b010);
        bus.write_ready = 1'b1;
        tick;
        bus.write_ready = 1'b0;
        repeat (15) tick;
        chk("to_hold", 64'(bus.grant), 64'b010);
        chk("to_early", 64'(bus.timeout_err), 64'd0);
        tick;
        chk("to_pulse", 64'(bus.timeout_err), 64'd1);
        chk("to_rel", 64'(bus.grant), 64'd0);
        bus.req_write_request[1] = 1'b0;
        tick;
        chk("to_pulse_end", 64'(bus.timeout_err), 64'd0);
        chk("to_gap", 64'(bus.grant), 64'd0);
        tick;
        chk("to_next", 64'(bus.grant), 64'b100);
        bus.write_done = 1'b1;
        #1;
        chk("to_next_done", 64'(bus.req_write_done), 64'b100);
        tick;
        bus.write_done = 1'b0;
        bus.req_write_request = '0;
        tick;

        // write_done on the same edge the watchdog expires
        bus.req_write_request = 3'b001;
        tick;
        chk("dt_grant", 64'(bus.grant), 64'b001);
        bus.write_ready = 1'b1;
        tick;
        bus.write_ready = 1'b0;
        repeat (15) tick;
        bus.write_done = 1'b1;
        #1;
        chk("dt_done", 64'(bus.req_write_done), 64'b001);
        tick;
        bus.write_done = 1'b0;
        chk("dt_no_tmo", 64'(bus.timeout_err), 64'd0);
        chk("dt_rel", 64'(bus.grant), 64'd0);
        chk("dt_busy", 64'(bus.busy), 64'd1);
        bus.req_write_request = '0;
        tick;

        // request dropped before any write_ready: abort
        bus.req_write_request = 3'b010;
        tick;
        chk("ab_grant", 64'(bus.grant), 64'b010);
        bus.req_write_request = '0;
        tick;
        chk("ab_rel", 64'(bus.grant), 64'd0);
        chk("ab_tmo", 64'(bus.timeout_err), 64'd0);
        chk("ab_busy", 64'(bus.busy), 64'd1);
        tick;
        chk("ab_idle", 64'(bus.busy), 64'd0);

        // reset mid-stream after 3 beats, then rr_ptr scan restarts at 0
        bus.req_write_request = 3'b001;
        tick;
        chk("rs_grant", 64'(bus.grant), 64'b001);
        bus.req_data_valid = 3'b001;
        repeat (3) tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_grant0", 64'(bus.grant), 64'd0);
        chk("rs_wr_req0", 64'(bus.write_request), 64'd0);
        chk("rs_valid0", 64'(bus.data_valid), 64'd0);
        chk("rs_busy0", 64'(bus.busy), 64'd0);
        bus.req_data_valid = '0;
        bus.req_write_request = '0;
        tick;
        tick;
        rst_n = 1'b1;
        bus.req_write_request = 3'b110;
        tick;
        chk("rs_rr0", 64'(bus.grant), 64'b010);
        bus.write_done = 1'b1;
        tick;
        bus.write_done = 1'b0;
        bus.req_write_request = '0;
        tick;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
